// File: rtl/snow_add_if.sv
// snow_add_if: requester operand/response bus plus external adder hookup for snow_add_arbiter
interface snow_add_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [31:0] rsp_data;
  modport master (
    output req_valid, req_a, req_b, add_sum,
    input req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input req_valid, req_a, req_b, add_sum,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/snow_add_arbiter.sv
// snow_add_arbiter: round-robin sharing of one external pipelined 32-bit adder,
// with a tag pipeline routing each sum back to its issuing requester.
module snow_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int ADD_LAT = 3,
  parameter int MAX_OUT = 2
) (
  input logic clk,
  input logic rst_n,
  input logic enable,
  snow_add_if.slave bus,
  output logic busy
);
  localparam int CW = 2;
  logic [ID_W-1:0] ptr_q, ptr_d, g;
  logic gnt;
  logic [NUM_REQ-1:0] elig, inc, dec;
  logic [CW-1:0] cnt_q [NUM_REQ];
  logic [CW-1:0] cnt_d [NUM_REQ];
  logic [ADD_LAT-1:0] tv_q;
  logic [ID_W-1:0] tid_q [ADD_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0] rsp_data_q;
  // scan downward so the lowest offset from ptr wins
  always_comb begin
    elig = '0;
    gnt = 1'b0;
    g = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = enable && bus.req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt = 1'b1;
        g = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end
  assign ptr_d = !gnt ? ptr_q : (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign bus.req_ready = gnt ? NUM_REQ'(1) << g : '0;
  assign bus.add_a = gnt ? bus.req_a[32*g +: 32] : '0;
  assign bus.add_b = gnt ? bus.req_b[32*g +: 32] : '0;
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i] = gnt && (g == ID_W'(i));
      dec[i] = tv_q[ADD_LAT-1] && (tid_q[ADD_LAT-1] == ID_W'(i));
      cnt_d[i] = cnt_q[i] + CW'(inc[i]) - CW'(dec[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      tv_q <= '0;
      rsp_valid_q <= '0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      tv_q[0] <= gnt;
      for (int k = 1; k < ADD_LAT; k++) tv_q[k] <= tv_q[k-1];
      rsp_valid_q <= tv_q[ADD_LAT-1] ? NUM_REQ'(1) << tid_q[ADD_LAT-1] : '0;
      if (tv_q[ADD_LAT-1]) begin
        rsp_id_q <= tid_q[ADD_LAT-1];
        rsp_data_q <= bus.add_sum;
      end
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  // ids only matter alongside a valid bit, so they need no reset
  always_ff @(posedge clk) begin
    tid_q[0] <= g;
    for (int k = 1; k < ADD_LAT; k++) tid_q[k] <= tid_q[k-1];
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q[i] <= CW'(MAX_OUT));
    a_cnt_under: assert property (@(posedge clk) disable iff (!rst_n) !(cnt_q[i] == '0 && dec[i] && !inc[i]));
  end
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  assign busy = (|tv_q) || (|rsp_valid_q);
endmodule
